// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package instr_fetch_ctrl_pkg;

  localparam int FETCH_ILEN = 32;
  localparam logic [FETCH_ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction-memory request/response port: one outstanding request, response valid pulse per grant.
interface instr_fetch_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int ILEN  = 32
);

  logic             Imem_Req;
  logic [WIDTH-1:0] Imem_Addr;
  logic             Imem_Gnt;
  logic             Imem_RValid;
  logic [ILEN-1:0]  Imem_RData;

  modport master (
    output Imem_Req,
    output Imem_Addr,
    input  Imem_Gnt,
    input  Imem_RValid,
    input  Imem_RData
  );

  modport slave (
    input  Imem_Req,
    input  Imem_Addr,
    output Imem_Gnt,
    output Imem_RValid,
    output Imem_RData
  );

endinterface

// File: rtl/instr_fetch_ctrl_skid_buf.sv
// One-entry {instr, pc} buffer parking a response that arrived while decode was stalled.
module fetch_skid_buf #(
  parameter int WIDTH = 32,
  parameter int ILEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [ILEN-1:0]  new_instr,
  input  logic [WIDTH-1:0] new_pc,
  output logic             valid,
  output logic [ILEN-1:0]  instr,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      instr <= new_instr;
      pc    <= new_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: issues PC to imem, waits for the response, and loads the IF/ID register.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int              WIDTH = 32,
  parameter int              ILEN  = FETCH_ILEN,
  parameter logic [ILEN-1:0] NOP   = NOP_INSTR
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [WIDTH-1:0]     PC,
  output logic                 Stall_F,
  input  logic                 Stall_D,
  input  logic                 Flush,
  instr_fetch_ctrl_if.master   imem,
  output logic [ILEN-1:0]      Instr_D,
  output logic [WIDTH-1:0]     PC_D,
  output logic                 Valid_D
);

  fetch_state_t     state, state_next;
  logic             drop, drop_next;
  logic [WIDTH-1:0] req_pc;

  logic             accept;
  logic             hold_release;
  logic             skid_load;
  logic             skid_clear;
  logic             skid_valid;
  logic [ILEN-1:0]  skid_instr;
  logic [WIDTH-1:0] skid_pc;

  assign imem.Imem_Req  = (state == REQ);
  assign imem.Imem_Addr = PC;

  // PC advances only when an instruction leaves fetch or a redirect target must be loaded.
  assign Stall_F = !(accept || hold_release || Flush);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  always_comb begin
    state_next   = state;
    drop_next    = drop;
    accept       = 1'b0;
    hold_release = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (imem.Imem_Gnt) begin
          state_next = WAIT;
          drop_next  = Flush;
        end
      end
      WAIT: begin
        if (imem.Imem_RValid) begin
          state_next = REQ;
          drop_next  = 1'b0;
          if (!drop && !Flush) begin
            if (Stall_D) begin
              skid_load  = 1'b1;
              state_next = HOLD;
            end else begin
              accept = 1'b1;
            end
          end
        end else if (Flush) begin
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (Flush) begin
          skid_clear = 1'b1;
          state_next = REQ;
        end else if (!Stall_D) begin
          hold_release = skid_valid;
          skid_clear   = 1'b1;
          state_next   = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if ((state == REQ) && imem.Imem_Gnt) begin
      req_pc <= PC;
    end
  end

  fetch_skid_buf #(
    .WIDTH (WIDTH),
    .ILEN  (ILEN)
  ) u_skid (
    .clk       (CLK),
    .rst_n     (Reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .new_instr (imem.Imem_RData),
    .new_pc    (req_pc),
    .valid     (skid_valid),
    .instr     (skid_instr),
    .pc        (skid_pc)
  );

  // IF/ID register: flush beats decode stall; an idle cycle inserts a bubble.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      Instr_D <= NOP;
      PC_D    <= '0;
      Valid_D <= 1'b0;
    end else if (Flush) begin
      Instr_D <= NOP;
      Valid_D <= 1'b0;
    end else if (!Stall_D) begin
      if (accept) begin
        Instr_D <= imem.Imem_RData;
        PC_D    <= req_pc;
        Valid_D <= 1'b1;
      end else if (hold_release) begin
        Instr_D <= skid_instr;
        PC_D    <= skid_pc;
        Valid_D <= 1'b1;
      end else begin
        Instr_D <= NOP;
        Valid_D <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: driver pushes expected IF/ID contents, negedge monitor pops them.
module tb_instr_fetch_ctrl;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic        Stall_F;
  logic        Stall_D;
  logic        Flush;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic        Valid_D;

  logic [31:0] tgt;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        e;
  bit          hold_prev = 1'b0;

  instr_fetch_ctrl_if #(.WIDTH(32), .ILEN(32)) bus ();

  instr_fetch_ctrl #(.WIDTH(32), .ILEN(32), .NOP(32'h0000_0013)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .PC      (PC),
    .Stall_F (Stall_F),
    .Stall_D (Stall_D),
    .Flush   (Flush),
    .imem    (bus),
    .Instr_D (Instr_D),
    .PC_D    (PC_D),
    .Valid_D (Valid_D)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Called at a negedge: models the PC register (loads on Stall_F=0) across the next rising edge.
  task automatic cyc();
    logic sf, fl;
    sf = Stall_F;
    fl = Flush;
    @(posedge CLK);
    #1;
    if (Reset && !sf) PC = fl ? tgt : PC + 32'd4;
  endtask

  task automatic fetch(input int gd, input int rd, input logic [31:0] data, input logic [31:0] pc_exp);
    for (int i = 0; i < gd; i++) begin
      bus.Imem_Gnt = 1'b0;
      @(negedge CLK);
      check1("gnt_wait_req", bus.Imem_Req, 1'b1);
      check("gnt_wait_addr", bus.Imem_Addr, pc_exp);
      check1("gnt_wait_stall_f", Stall_F, 1'b1);
      cyc();
    end
    bus.Imem_Gnt = 1'b1;
    @(negedge CLK);
    check1("req", bus.Imem_Req, 1'b1);
    check("req_addr", bus.Imem_Addr, pc_exp);
    check1("req_stall_f", Stall_F, 1'b1);
    cyc();
    bus.Imem_Gnt = 1'b0;
    for (int i = 0; i < rd; i++) begin
      @(negedge CLK);
      check1("wait_req", bus.Imem_Req, 1'b0);
      check1("wait_stall_f", Stall_F, 1'b1);
      cyc();
    end
    bus.Imem_RValid = 1'b1;
    bus.Imem_RData  = data;
    sb.push_back('{data, pc_exp});
    @(negedge CLK);
    check1("accept_stall_f", Stall_F, 1'b0);
    cyc();
    bus.Imem_RValid = 1'b0;
  endtask

  // A new IF/ID value appears only after an edge where decode was not holding it.
  always @(negedge CLK) begin
    if (Reset === 1'b1 && Valid_D === 1'b1 && !hold_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual pc=%h instr=%h required no output", PC_D, Instr_D);
      end else begin
        e = sb.pop_front();
        check("ifid_instr", Instr_D, e.instr);
        check("ifid_pc", PC_D, e.pc);
      end
    end
    hold_prev = Stall_D && !Flush;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    Reset = 1'b0;
    PC = 32'h0;
    Stall_D = 1'b0;
    Flush = 1'b0;
    tgt = 32'h0;
    bus.Imem_Gnt = 1'b0;
    bus.Imem_RValid = 1'b0;
    bus.Imem_RData = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check1("rst_valid", Valid_D, 1'b0);
    check("rst_instr", Instr_D, 32'h0000_0013);
    check("rst_pc_d", PC_D, 32'h0);
    check1("rst_req", bus.Imem_Req, 1'b0);
    check1("rst_stall_f", Stall_F, 1'b1);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(negedge CLK);
    check1("idle_req", bus.Imem_Req, 1'b0);
    cyc();

    // Zero-wait, then delayed grant/response, then back-to-back.
    fetch(0, 0, 32'h0050_0093, 32'h0);
    @(negedge CLK);
    check1("one_cycle_stall_f", Stall_F, 1'b1);
    check("advanced_addr", bus.Imem_Addr, 32'h4);
    cyc();
    fetch(2, 2, 32'h00a0_0113, 32'h4);
    fetch(0, 0, 32'h0020_81b3, 32'h8);

    // Decode stall across response arrival.
    Stall_D = 1'b1;
    bus.Imem_Gnt = 1'b1;
    @(negedge CLK);
    check("stall_req_addr", bus.Imem_Addr, 32'hc);
    cyc();
    bus.Imem_Gnt = 1'b0;
    bus.Imem_RValid = 1'b1;
    bus.Imem_RData = 32'h4000_0213;
    sb.push_back('{32'h4000_0213, 32'hc});
    @(negedge CLK);
    check1("stall_rv_stall_f", Stall_F, 1'b1);
    check1("stall_held_valid", Valid_D, 1'b1);
    check("stall_held_instr", Instr_D, 32'h0020_81b3);
    cyc();
    bus.Imem_RValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check1("hold_stall_f", Stall_F, 1'b1);
      check1("hold_req", bus.Imem_Req, 1'b0);
      check1("hold_valid", Valid_D, 1'b1);
      check("hold_instr", Instr_D, 32'h0020_81b3);
      cyc();
    end
    Stall_D = 1'b0;
    @(negedge CLK);
    check1("release_stall_f", Stall_F, 1'b0);
    cyc();

    // Flush while waiting, response arrives two cycles later and is dropped.
    bus.Imem_Gnt = 1'b1;
    @(negedge CLK);
    check("flush_wait_req_addr", bus.Imem_Addr, 32'h10);
    cyc();
    bus.Imem_Gnt = 1'b0;
    Flush = 1'b1;
    tgt = 32'h40;
    @(negedge CLK);
    check1("flush_wait_stall_f", Stall_F, 1'b0);
    cyc();
    Flush = 1'b0;
    @(negedge CLK);
    check1("drop_wait_req", bus.Imem_Req, 1'b0);
    check1("drop_wait_stall_f", Stall_F, 1'b1);
    cyc();
    bus.Imem_RValid = 1'b1;
    bus.Imem_RData = 32'hdead_beef;
    @(negedge CLK);
    check1("drop_rv_stall_f", Stall_F, 1'b1);
    cyc();
    bus.Imem_RValid = 1'b0;
    @(negedge CLK);
    check1("post_drop_valid", Valid_D, 1'b0);
    check("post_drop_instr", Instr_D, 32'h0000_0013);
    check1("post_drop_req", bus.Imem_Req, 1'b1);
    check("post_drop_addr", bus.Imem_Addr, 32'h40);
    cyc();
    fetch(0, 0, 32'h0000_0517, 32'h40);

    // Flush coinciding with the response.
    bus.Imem_Gnt = 1'b1;
    @(negedge CLK);
    cyc();
    bus.Imem_Gnt = 1'b0;
    bus.Imem_RValid = 1'b1;
    bus.Imem_RData = 32'h0bad_c0de;
    Flush = 1'b1;
    tgt = 32'h80;
    @(negedge CLK);
    check1("flush_rv_stall_f", Stall_F, 1'b0);
    cyc();
    bus.Imem_RValid = 1'b0;
    Flush = 1'b0;
    @(negedge CLK);
    check1("flush_rv_valid", Valid_D, 1'b0);
    check("flush_rv_instr", Instr_D, 32'h0000_0013);
    check1("flush_rv_req", bus.Imem_Req, 1'b1);
    check("flush_rv_addr", bus.Imem_Addr, 32'h80);
    cyc();
    fetch(0, 1, 32'h0080_00ef, 32'h80);

    // Flush while a stalled response sits in the skid buffer.
    bus.Imem_Gnt = 1'b1;
    @(negedge CLK);
    cyc();
    bus.Imem_Gnt = 1'b0;
    bus.Imem_RValid = 1'b1;
    bus.Imem_RData = 32'h1111_1111;
    Stall_D = 1'b1;
    @(negedge CLK);
    cyc();
    bus.Imem_RValid = 1'b0;
    Flush = 1'b1;
    tgt = 32'hc0;
    @(negedge CLK);
    check1("flush_hold_stall_f", Stall_F, 1'b0);
    cyc();
    Flush = 1'b0;
    Stall_D = 1'b0;
    @(negedge CLK);
    check1("flush_hold_req", bus.Imem_Req, 1'b1);
    check1("flush_hold_valid", Valid_D, 1'b0);
    check("flush_hold_addr", bus.Imem_Addr, 32'hc0);
    cyc();
    fetch(1, 0, 32'h2222_2222, 32'hc0);

    // Flush in the grant cycle: the eventual response must be dropped.
    bus.Imem_Gnt = 1'b1;
    Flush = 1'b1;
    tgt = 32'h100;
    @(negedge CLK);
    check1("flush_gnt_stall_f", Stall_F, 1'b0);
    cyc();
    bus.Imem_Gnt = 1'b0;
    Flush = 1'b0;
    bus.Imem_RValid = 1'b1;
    bus.Imem_RData = 32'h3333_3333;
    @(negedge CLK);
    check1("drop_gnt_rv_stall_f", Stall_F, 1'b1);
    cyc();
    bus.Imem_RValid = 1'b0;
    @(negedge CLK);
    check1("drop_gnt_req", bus.Imem_Req, 1'b1);
    check("drop_gnt_addr", bus.Imem_Addr, 32'h100);
    check1("drop_gnt_valid", Valid_D, 1'b0);
    cyc();
    fetch(0, 0, 32'h4444_4444, 32'h100);

    // Reset in the middle of an outstanding request.
    bus.Imem_Gnt = 1'b1;
    @(negedge CLK);
    cyc();
    bus.Imem_Gnt = 1'b0;
    Reset = 1'b0;
    PC = 32'h0;
    @(negedge CLK);
    check1("mid_rst_valid", Valid_D, 1'b0);
    check("mid_rst_instr", Instr_D, 32'h0000_0013);
    check1("mid_rst_req", bus.Imem_Req, 1'b0);
    check1("mid_rst_stall_f", Stall_F, 1'b1);
    cyc();
    Reset = 1'b1;
    @(negedge CLK);
    check1("rel_idle_req", bus.Imem_Req, 1'b0);
    cyc();
    fetch(0, 0, 32'h5555_5555, 32'h0);

    @(negedge CLK);
    #1;
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
